mux_2to1: RTL and testbench



---
 rtl/mux_2to1_if.sv | 12 +
 rtl/mux_2to1.sv | 38 +++
 tb/tb_mux_2to1.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mux_2to1_if.sv
// Bus bundle for the two-input data selector: two candidate words, a select and the steered result.
interface mux_2to1_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in0;
  logic [WIDTH-1:0] data_in1;
  logic             sel;
  logic [WIDTH-1:0] data_out;

  modport master (output data_in0, output data_in1, output sel, input data_out);
  modport slave  (input data_in0, input data_in1, input sel, output data_out);
endinterface

// File: rtl/mux_2to1.sv
// Two-input WIDTH-bit data selector followed by an optional PIPE-deep register chain
// with synchronous active-low reset. PIPE = 0 yields a purely combinational path.
module mux_2to1 #(
  parameter int WIDTH = 8,
  parameter int PIPE  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  mux_2to1_if.slave  bus
);

  logic [WIDTH-1:0] mux_value;

  // An unknown select must not poison the output, so anything other than a clean 1 picks data_in0.
  assign mux_value = (bus.sel === 1'b1) ? bus.data_in1 : bus.data_in0;

  if (PIPE == 0) begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign bus.data_out   = mux_value;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [PIPE];

    // NOTE: sequential state uses non-blocking assignments so every stage samples its
    // predecessor's pre-edge value; every stage is reset so in-flight words are discarded.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < PIPE; i++) stage[i] <= '0;
      end else begin
        stage[0] <= mux_value;
        for (int i = 1; i < PIPE; i++) stage[i] <= stage[i-1];
      end
    end

    assign bus.data_out = stage[PIPE-1];
  end

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench: four selector instances (pipelined, deep, combinational, wide)
// compared against a delay-line reference model under directed and random stimulus.
module tb_mux_2to1;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cnt3;

  mux_2to1_if #(.WIDTH(8))  b8  ();
  mux_2to1_if #(.WIDTH(8))  b3  ();
  mux_2to1_if #(.WIDTH(8))  b0  ();
  mux_2to1_if #(.WIDTH(32)) b32 ();

  mux_2to1 #(.WIDTH(8),  .PIPE(1)) dut_p1  (.clk(clk), .rst_n(rst_n), .bus(b8));
  mux_2to1 #(.WIDTH(8),  .PIPE(3)) dut_p3  (.clk(clk), .rst_n(rst_n), .bus(b3));
  mux_2to1 #(.WIDTH(8),  .PIPE(0)) dut_p0  (.clk(clk), .rst_n(rst_n), .bus(b0));
  mux_2to1 #(.WIDTH(32), .PIPE(1)) dut_w32 (.clk(clk), .rst_n(rst_n), .bus(b32));

  // Reference delay lines: entry 0 is what the output must show after the latest edge.
  logic [31:0] q1  [$];
  logic [31:0] q3  [$];
  logic [31:0] q32 [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic s, input logic [31:0] a, input logic [31:0] b);
    return (s === 1'b1) ? b : a;
  endfunction

  // One rising edge: advance the model with the values present at the edge, then compare.
  task automatic step();
    logic [31:0] v1, v3, v32;
    @(posedge clk);
    v1  = pick(b8.sel,  32'(b8.data_in0),  32'(b8.data_in1));
    v3  = pick(b3.sel,  32'(b3.data_in0),  32'(b3.data_in1));
    v32 = pick(b32.sel, b32.data_in0,      b32.data_in1);
    if (!rst_n) begin
      foreach (q1[i])  q1[i]  = '0;
      foreach (q3[i])  q3[i]  = '0;
      foreach (q32[i]) q32[i] = '0;
    end else begin
      q1.push_back(v1);   void'(q1.pop_front());
      q3.push_back(v3);   void'(q3.pop_front());
      q32.push_back(v32); void'(q32.pop_front());
    end
    #1;
    check("p1_w8",  32'(b8.data_out), q1[0]);
    check("p3_w8",  32'(b3.data_out), q3[0]);
    check("p1_w32", b32.data_out,     q32[0]);
    check("p0_w8",  32'(b0.data_out), pick(b0.sel, 32'(b0.data_in0), 32'(b0.data_in1)));
  endtask

  // Combinational instance must follow select changes between edges, reset or not.
  task automatic comb_toggle();
    for (int i = 0; i < 3; i++) begin
      b0.sel = ~b0.sel;
      #1;
      check("p0_toggle", 32'(b0.data_out), pick(b0.sel, 32'(b0.data_in0), 32'(b0.data_in1)));
    end
  endtask

  task automatic drive_incr();
    cnt3++;
    b3.data_in1 = 8'(cnt3);
    b3.sel      = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cnt3  = 0;
    q1  = '{32'h0};
    q3  = '{32'h0, 32'h0, 32'h0};
    q32 = '{32'h0};

    rst_n        = 1'b0;
    b8.data_in0  = 8'd15; b8.data_in1 = 8'd5;  b8.sel = 1'b0;
    b3.data_in0  = 8'hFF; b3.data_in1 = 8'h0;  b3.sel = 1'b1;
    b0.data_in0  = 8'hAA; b0.data_in1 = 8'h55; b0.sel = 1'b0;
    b32.data_in0 = 32'hDEADBEEF; b32.data_in1 = 32'h12345678; b32.sel = 1'b0;

    // Reset held for two edges, combinational path unaffected.
    repeat (2) begin
      step();
      comb_toggle();
    end

    // Release: sel=0 for 10 cycles, incrementing stream into the deep chain, unknown select on the wide one.
    rst_n   = 1'b1;
    b32.sel = 1'bx;
    repeat (10) begin
      drive_incr();
      step();
      comb_toggle();
    end

    b8.sel  = 1'b1;
    b32.sel = 1'b1;
    repeat (4) begin
      drive_incr();
      step();
    end

    // Mid-stream reset discards in-flight words, stream resumes afterwards.
    rst_n = 1'b0;
    drive_incr();
    step();
    comb_toggle();
    rst_n   = 1'b1;
    b8.sel  = 1'b0;
    repeat (6) begin
      drive_incr();
      step();
    end

    // Random traffic with occasional reset pulses.
    repeat (300) begin
      rst_n        = ($urandom_range(0, 19) != 0);
      b8.data_in0  = 8'($urandom); b8.data_in1  = 8'($urandom); b8.sel  = 1'($urandom);
      b3.data_in0  = 8'($urandom); b3.data_in1  = 8'($urandom); b3.sel  = 1'($urandom);
      b0.data_in0  = 8'($urandom); b0.data_in1  = 8'($urandom); b0.sel  = 1'($urandom);
      b32.data_in0 = $urandom;     b32.data_in1 = $urandom;     b32.sel = 1'($urandom);
      step();
      if ($urandom_range(0, 3) == 0) comb_toggle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
